led_array_ctrl: RTL and testbench

Parametrised multi-channel output driver. Each of NCH channels maps one input bit VAL[i] to one registered output LED[i] under a per-channel 2-bit mode: off, pass, invert or blink. Modes are run-time programmable through a valid/ready config port with unicast and broadcast writes. A shared prescaler provides the blink timebase. The block replaces hand-instantiated per-bit fixed-mode cells.

---
 rtl/led_array_ctrl.sv | 112 +++++++++++
 tb/tb_led_array_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/led_array_ctrl.sv
// led_array_ctrl: multi-channel LED output driver with per-channel run-time modes
// (off / pass / invert / blink), a valid/ready config port with unicast and
// broadcast writes, and a shared prescaler that provides the blink timebase.
//
// Config FSM states:
//   state | meaning
//   IDLE  | ready for a config write, CFG_READY = 1
//   HOLD  | one-cycle recovery after an accepted write, CFG_READY = 0
module led_array_ctrl #(
  parameter int NCH          = 4,
  parameter int CH_W         = 2,
  parameter int PRESCALE     = 1000,
  parameter int CNT_W        = 10,
  parameter int DEFAULT_MODE = 2
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [NCH-1:0]  VAL,
  input  logic            CFG_VALID,
  output logic            CFG_READY,
  input  logic            CFG_ALL,
  input  logic [CH_W-1:0] CFG_CH,
  input  logic [1:0]      CFG_MODE,
  output logic            CFG_ERR,
  output logic            TICK,
  output logic [NCH-1:0]  LED
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);
  // One extra bit so NCH == 2**CH_W is representable in the range check.
  localparam logic [CH_W:0]    NCH_LIM  = (CH_W + 1)'(NCH);
  localparam logic [1:0]       MODE_RST = 2'(DEFAULT_MODE);

  state_t           state;
  logic [1:0]       mode [NCH];
  logic [CNT_W-1:0] cnt;
  logic             phase;
  logic             accept;
  logic             in_range;

  assign accept   = CFG_VALID & CFG_READY;
  assign in_range = {1'b0, CFG_CH} < NCH_LIM;

  // Config handshake FSM; commits mode writes on the accept edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      CFG_READY <= 1'b1;
      CFG_ERR   <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        mode[i] <= MODE_RST;
      end
    end else begin
      CFG_ERR <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state     <= HOLD;
            CFG_READY <= 1'b0;
            CFG_ERR   <= ~CFG_ALL & ~in_range;
            for (int i = 0; i < NCH; i++) begin
              if (CFG_ALL || (CFG_CH == CH_W'(i))) begin
                mode[i] <= CFG_MODE;
              end
            end
          end
        end
        HOLD: begin
          state     <= IDLE;
          CFG_READY <= 1'b1;
        end
      endcase
    end
  end

  // Prescaler: wrapping counter, registered tick, blink phase toggled per tick.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt   <= '0;
      TICK  <= 1'b0;
      phase <= 1'b0;
    end else begin
      TICK <= (cnt == CNT_LAST);
      cnt  <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
      if (TICK) begin
        phase <= ~phase;
      end
    end
  end

  // Per-channel output mapping from the current mode and blink phase.
  always_ff @(posedge CLK) begin
    if (RST) begin
      LED <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        case (mode[i])
          2'd0:    LED[i] <= 1'b0;
          2'd1:    LED[i] <= VAL[i];
          2'd2:    LED[i] <= ~VAL[i];
          default: LED[i] <= VAL[i] & phase;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_led_array_ctrl.sv
// Bench for led_array_ctrl: two instances (4 channels / prescale 4, and
// 3 channels / prescale 1) share one stimulus stream. A directed table, a
// hand-written out-of-range sequence and a random phase are all compared
// against expected values computed in the bench.
module tb_led_array_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_valid;
  logic       cfg_all;
  logic [1:0] cfg_ch;
  logic [1:0] cfg_mode;
  logic [3:0] val;

  logic       ready0, err0, tick0;
  logic [3:0] led0;
  logic       ready1, err1, tick1;
  logic [2:0] led1;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  led_array_ctrl #(
    .NCH(4), .CH_W(2), .PRESCALE(4), .CNT_W(2), .DEFAULT_MODE(2)
  ) dut0 (
    .CLK(clk), .RST(rst), .VAL(val), .CFG_VALID(cfg_valid), .CFG_READY(ready0),
    .CFG_ALL(cfg_all), .CFG_CH(cfg_ch), .CFG_MODE(cfg_mode), .CFG_ERR(err0),
    .TICK(tick0), .LED(led0)
  );

  led_array_ctrl #(
    .NCH(3), .CH_W(2), .PRESCALE(1), .CNT_W(1), .DEFAULT_MODE(1)
  ) dut1 (
    .CLK(clk), .RST(rst), .VAL(val[2:0]), .CFG_VALID(cfg_valid), .CFG_READY(ready1),
    .CFG_ALL(cfg_all), .CFG_CH(cfg_ch), .CFG_MODE(cfg_mode), .CFG_ERR(err1),
    .TICK(tick1), .LED(led1)
  );

  // Reference model: cycle count since reset drives tick and phase arithmetically.
  int nch_m [2] = '{4, 3};
  int pre_m [2] = '{4, 1};
  int def_m [2] = '{2, 1};
  int k_m   [2] = '{0, 0};
  int mode_m[2][4];
  int led_m [2] = '{0, 0};
  bit busy_m[2] = '{1'b0, 1'b0};
  bit err_m [2] = '{1'b0, 1'b0};

  function automatic bit phase_of(int k, int p);
    return (k == 0) ? 1'b0 : bit'(((k - 1) / p) % 2);
  endfunction

  function automatic bit tick_of(int k, int p);
    return (k >= p) && (k % p == 0);
  endfunction

  task automatic model_edge();
    for (int m = 0; m < 2; m++) begin
      if (rst) begin
        k_m[m] = 0;
        for (int i = 0; i < 4; i++) mode_m[m][i] = def_m[m];
        busy_m[m] = 1'b0;
        err_m[m]  = 1'b0;
        led_m[m]  = 0;
      end else begin
        bit ph, acc, b;
        int nl;
        ph = phase_of(k_m[m], pre_m[m]);
        nl = 0;
        for (int i = 0; i < nch_m[m]; i++) begin
          case (mode_m[m][i])
            0:       b = 1'b0;
            1:       b = val[i];
            2:       b = !val[i];
            default: b = val[i] & ph;
          endcase
          if (b) nl = nl | (1 << i);
        end
        led_m[m] = nl;
        k_m[m]   = k_m[m] + 1;
        acc      = cfg_valid && !busy_m[m];
        err_m[m] = acc && !cfg_all && (int'(cfg_ch) >= nch_m[m]);
        if (acc) begin
          if (cfg_all) begin
            for (int i = 0; i < nch_m[m]; i++) mode_m[m][i] = int'(cfg_mode);
          end else if (int'(cfg_ch) < nch_m[m]) begin
            mode_m[m][cfg_ch] = int'(cfg_mode);
          end
        end
        busy_m[m] = acc;
      end
    end
  endtask

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic check_model();
    check("m_led0",   32'(led0),   32'(led_m[0]));
    check("m_ready0", 32'(ready0), 32'(!busy_m[0]));
    check("m_err0",   32'(err0),   32'(err_m[0]));
    check("m_tick0",  32'(tick0),  32'(tick_of(k_m[0], pre_m[0])));
    check("m_led1",   32'(led1),   32'(led_m[1]));
    check("m_ready1", 32'(ready1), 32'(!busy_m[1]));
    check("m_err1",   32'(err1),   32'(err_m[1]));
    check("m_tick1",  32'(tick1),  32'(tick_of(k_m[1], pre_m[1])));
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check_model();
  endtask

  typedef struct {
    logic       rst;
    logic       valid;
    logic       all;
    logic [1:0] ch;
    logic [1:0] mode;
    logic [3:0] val;
    logic [3:0] led;
    logic       ready;
    logic       tick;
  } vec_t;

  vec_t tbl[25];

  initial begin
    // rst valid all ch mode val | led ready tick   (instance dut0)
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 4'b0101, 4'b0000, 1'b1, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 4'b0101, 4'b1010, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 2'd1, 2'd1, 4'b0010, 4'b1101, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 2'd1, 2'd1, 4'b0010, 4'b1111, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 2'd2, 2'd0, 4'b0010, 4'b1111, 1'b0, 1'b1};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 4'b0010, 4'b1011, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 1'b1, 2'd3, 2'd3, 4'b1111, 4'b0010, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 4'b1111, 4'b1111, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 4'b0000, 4'b0000, 1'b1, 1'b1};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 4'b1111, 4'b1111, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 4'b1111, 4'b0000, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 4'b1111, 4'b0000, 1'b1, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 4'b0000, 4'b0000, 1'b1, 1'b1};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 4'b1111, 4'b0000, 1'b1, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 4'b1111, 4'b1111, 1'b1, 1'b0};
    tbl[15] = '{1'b0, 1'b1, 1'b1, 2'd0, 2'd0, 4'b1111, 4'b1111, 1'b0, 1'b0};
    tbl[16] = '{1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 4'b1111, 4'b0000, 1'b1, 1'b1};
    tbl[17] = '{1'b0, 1'b1, 1'b0, 2'd3, 2'd2, 4'b0000, 4'b0000, 1'b0, 1'b0};
    tbl[18] = '{1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 4'b0000, 4'b1000, 1'b1, 1'b0};
    tbl[19] = '{1'b0, 1'b1, 1'b0, 2'd0, 2'd1, 4'b0101, 4'b1000, 1'b0, 1'b0};
    tbl[20] = '{1'b1, 1'b1, 1'b0, 2'd0, 2'd1, 4'b0101, 4'b0000, 1'b1, 1'b0};
    tbl[21] = '{1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 4'b0101, 4'b1010, 1'b1, 1'b0};
    tbl[22] = '{1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 4'b0101, 4'b1010, 1'b1, 1'b0};
    tbl[23] = '{1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 4'b0101, 4'b1010, 1'b1, 1'b0};
    tbl[24] = '{1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 4'b0101, 4'b1010, 1'b1, 1'b1};

    rst = 1'b1; cfg_valid = 1'b0; cfg_all = 1'b0; cfg_ch = 2'd0; cfg_mode = 2'd0; val = 4'd0;
    @(posedge clk); #1;

    for (int r = 0; r < 25; r++) begin
      rst = tbl[r].rst; cfg_valid = tbl[r].valid; cfg_all = tbl[r].all;
      cfg_ch = tbl[r].ch; cfg_mode = tbl[r].mode; val = tbl[r].val;
      step();
      check($sformatf("tbl%0d_led", r),   32'(led0),   32'(tbl[r].led));
      check($sformatf("tbl%0d_ready", r), 32'(ready0), 32'(tbl[r].ready));
      check($sformatf("tbl%0d_tick", r),  32'(tick0),  32'(tbl[r].tick));
      check($sformatf("tbl%0d_err", r),   32'(err0),   32'd0);
    end

    // Out-of-range unicast on the 3-channel instance: all pass, VAL=101.
    cfg_valid = 1'b1; cfg_all = 1'b1; cfg_mode = 2'd1; val = 4'b0101;
    step();
    cfg_valid = 1'b0; cfg_all = 1'b0;
    step();
    check("oor_pre_led1", 32'(led1), 32'b101);
    cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_mode = 2'd0;
    step();
    check("oor_err_pulse", 32'(err1),   32'd1);
    check("oor_ready_low", 32'(ready1), 32'd0);
    check("oor_led_kept",  32'(led1),   32'b101);
    cfg_valid = 1'b0;
    step();
    check("oor_err_clear", 32'(err1),   32'd0);
    check("oor_ready_back", 32'(ready1), 32'd1);
    check("oor_mode_kept", 32'(led1),   32'b101);
    step();
    check("oor_mode_kept2", 32'(led1),  32'b101);

    // Randomized traffic, occasional resets, both instances against the model.
    for (int c = 0; c < 600; c++) begin
      rst       = ($urandom_range(0, 49) == 0);
      cfg_valid = $urandom_range(0, 1) == 1;
      cfg_all   = ($urandom_range(0, 3) == 0);
      cfg_ch    = 2'($urandom_range(0, 3));
      cfg_mode  = 2'($urandom_range(0, 3));
      val       = 4'($urandom_range(0, 15));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
